// File: rtl/commit_cmp_pkg.sv
// Shared types for the dual commit comparator: comparator state and the stored commit entry.
// Defining COMMIT_CMP_WDATA_EN adds the write-back data field to the stored entry.
package commit_cmp_pkg;

  // Widest supported PC / write-back field; narrower XLEN values are zero-extended into it.
  localparam int unsigned MAX_XLEN = 64;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MISMATCH = 2'd1,
    ST_OVERFLOW = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] pc;
    logic [31:0]         insn;
`ifdef COMMIT_CMP_WDATA_EN
    logic [MAX_XLEN-1:0] wdata;
`endif
  } commit_entry_t;

  // Only compared fields are stored, so whole-entry inequality is exactly the divergence rule.
  function automatic logic entries_differ(input commit_entry_t a, input commit_entry_t b);
    return a != b;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous DEPTH-entry FIFO with occupancy count; pointers carry an extra wrap bit.
// A push is accepted at full when a pop happens on the same edge.
module commit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/dual_commit_comparator.sv
// Lock-step checker: buffers DUT and variant commit streams and compares them pairwise.
// Build option COMMIT_CMP_WDATA_EN: also store and compare write-back data.
module dual_commit_comparator
  import commit_cmp_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   dut_valid,
  input  logic [XLEN-1:0]        dut_pc,
  input  logic [31:0]            dut_insn,
  input  logic [XLEN-1:0]        dut_wdata,
  input  logic                   vnt_valid,
  input  logic [XLEN-1:0]        vnt_pc,
  input  logic [31:0]            vnt_insn,
  input  logic [XLEN-1:0]        vnt_wdata,
  output logic                   mismatch,
  output logic                   overflow,
  output logic [XLEN-1:0]        fail_pc_dut,
  output logic [XLEN-1:0]        fail_pc_vnt,
  output logic [63:0]            compared,
  output logic [$clog2(DEPTH):0] skew
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(commit_entry_t);

  cmp_state_e    state;
  commit_entry_t dut_in, vnt_in, dut_head, vnt_head;
  logic          dut_full, dut_empty, vnt_full, vnt_empty;
  logic [CW-1:0] dut_count, vnt_count;
  logic          run, pop, dut_push, vnt_push, overrun, diverge;

  // NOTE: every field gets a default before selective assignment so no latch is inferred.
  always_comb begin
    dut_in      = '0;
    vnt_in      = '0;
    dut_in.pc   = MAX_XLEN'(dut_pc);
    dut_in.insn = dut_insn;
    vnt_in.pc   = MAX_XLEN'(vnt_pc);
    vnt_in.insn = vnt_insn;
`ifdef COMMIT_CMP_WDATA_EN
    dut_in.wdata = MAX_XLEN'(dut_wdata);
    vnt_in.wdata = MAX_XLEN'(vnt_wdata);
`endif
  end

`ifndef COMMIT_CMP_WDATA_EN
  logic unused_wdata;
  assign unused_wdata = ^{dut_wdata, vnt_wdata};
`endif

  assign run      = (state == ST_RUN);
  assign pop      = run && !dut_empty && !vnt_empty;
  assign dut_push = run && dut_valid && (!dut_full || pop);
  assign vnt_push = run && vnt_valid && (!vnt_full || pop);
  assign overrun  = run && !pop && ((dut_valid && dut_full) || (vnt_valid && vnt_full));
  assign diverge  = pop && entries_differ(dut_head, vnt_head);

  commit_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_dut_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (dut_push),
    .push_data (dut_in),
    .pop       (pop),
    .head      (dut_head),
    .full      (dut_full),
    .empty     (dut_empty),
    .count     (dut_count)
  );

  commit_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_vnt_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (vnt_push),
    .push_data (vnt_in),
    .pop       (pop),
    .head      (vnt_head),
    .full      (vnt_full),
    .empty     (vnt_empty),
    .count     (vnt_count)
  );

  // Divergence is tested first so it wins over a same-edge overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      fail_pc_dut <= '0;
      fail_pc_vnt <= '0;
      compared    <= '0;
    end else if (run) begin
      if (diverge) begin
        state       <= ST_MISMATCH;
        fail_pc_dut <= XLEN'(dut_head.pc);
        fail_pc_vnt <= XLEN'(vnt_head.pc);
      end else if (overrun) begin
        state <= ST_OVERFLOW;
      end else if (pop) begin
        compared <= compared + 64'd1;
      end
    end
  end

  assign mismatch = (state == ST_MISMATCH);
  assign overflow = (state == ST_OVERFLOW);
  assign skew     = dut_count - vnt_count;

endmodule

// File: doc/dual_commit_comparator.md
DUAL_COMMIT_COMPARATOR -- requirements
Module: dual_commit_comparator

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of the PC and write-back data fields.
REQ-002 SHALL have parameter DEPTH, default 8: per-side FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports dut_valid, dut_pc, dut_insn, dut_wdata: inputs of width 1/XLEN/32/XLEN carrying the DUT harness commit event.
REQ-006 SHALL have ports vnt_valid, vnt_pc, vnt_insn, vnt_wdata: inputs of width 1/XLEN/32/XLEN carrying the variant harness commit event.
REQ-007 SHALL have port mismatch, output, 1: sticky divergence flag.
REQ-008 SHALL have port overflow, output, 1: sticky FIFO-overrun flag.
REQ-009 SHALL have ports fail_pc_dut and fail_pc_vnt, outputs, XLEN each: PCs of the first diverging pair.
REQ-010 SHALL have port compared, output, 64: count of matched pairs.
REQ-011 SHALL have port skew, output, $clog2(DEPTH)+1: dut FIFO occupancy minus vnt FIFO occupancy, two's complement.

Function
REQ-012 SHALL push each side's {pc, insn, wdata} into its own FIFO on a rising edge where that side's valid is 1; commit inputs are never back-pressured.
REQ-013 SHALL pop both FIFOs on the same edge when both are non-empty and the state is RUN, comparing the head entries.
REQ-014 SHALL compare pc and insn, and wdata only per REQ-024; any difference is a divergence.
REQ-015 SHALL, for a pair pushed on edge t into empty FIFOs, register the compare result on edge t+1: mismatch high, or compared incremented.
REQ-016 SHALL implement the states RUN, MISMATCH and OVERFLOW with these transitions:
- RUN to MISMATCH on divergence.
- RUN to OVERFLOW on overrun.
- MISMATCH and OVERFLOW are terminal until reset.
REQ-017 SHALL detect an overrun when a push arrives at a full FIFO with no same-edge pop; a push with a same-edge pop at full is legal.
REQ-018 SHALL give divergence priority over overrun when both are detected on the same edge.
REQ-019 SHALL capture fail_pc_dut and fail_pc_vnt only on the RUN-to-MISMATCH edge and hold them afterwards.
REQ-020 SHALL stop popping and counting outside RUN; pushes are then ignored and skew freezes.
REQ-021 SHALL wrap compared modulo 2^64 and handle FIFO pointers with an extra wrap bit so full and empty are distinguishable.

Reset
REQ-022 SHALL, while reset is low, asynchronously force:
- state to RUN;
- FIFOs to empty;
- mismatch, overflow, fail_pc_dut, fail_pc_vnt, compared and skew to 0.
REQ-023 SHALL discard all in-flight entries on reset assertion mid-operation, with no partial compare.

Configuration
REQ-024 SHALL, with COMMIT_CMP_WDATA_EN defined, store and compare wdata; without it, drop wdata from FIFO storage, leave the wdata ports unused, and compare pc and insn only.

Structure
REQ-025 SHALL place the commit-entry struct typedef and the state enum in package commit_cmp_pkg.
REQ-026 SHALL instantiate sub-module commit_fifo twice: a parameterized DEPTH-entry synchronous FIFO with count output.

Verification
REQ-027 SHALL cover: 100 identical pairs, both sides lock-step -> mismatch=0, compared=100, skew=0.
REQ-028 SHALL cover: dut commits 5 ahead of vnt, then vnt catches up with identical stream -> skew peaks at 5, mismatch=0, compared=5.
REQ-029 SHALL cover: pair 3 with dut_pc=0x80000010 and vnt_pc=0x80000014 -> mismatch=1 one cycle after the pair completes, fail PCs captured, compared=2 and frozen.
REQ-030 SHALL cover: identical pc/insn but wdata 0x1 vs 0x2 -> mismatch=1 with COMMIT_CMP_WDATA_EN, compared increments without it.
REQ-031 SHALL cover: DEPTH+1 dut commits with no vnt commits -> overflow=1 on the 9th push (DEPTH=8), mismatch=0.
REQ-032 SHALL cover: reset asserted in MISMATCH with 3 entries queued -> all outputs 0 immediately, and a fresh identical stream afterwards compares cleanly.
